// File: rtl/yaw_integrator.sv
// yaw_integrator: calibrates a gyro zero-rate offset, then integrates corrected yaw rate (plus optional IR fusion) into a 12-bit wrapping heading.
module yaw_integrator #(
    parameter bit FAST_SIM = 1'b0,
    parameter int FUS_SHL  = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               strt_cal,
    input  logic               vld,
    input  logic signed [15:0] yaw_rt,
    input  logic               moving,
    input  logic               en_fusion,
    input  logic signed [8:0]  IR_Dtrm,
    output logic               cal_done,
    output logic               rdy,
    output logic        [11:0] heading
);
    localparam int CAL_LOG2 = FAST_SIM ? 8 : 11;
    localparam logic [11:0] CAL_LAST = 12'((1 << CAL_LOG2) - 1);

    typedef enum logic [1:0] {IDLE, CAL, RUN} state_t;

    state_t             state, state_nxt;
    logic signed [26:0] cal_acc, cal_sum, acc, acc_sum, delta;
    logic        [11:0] cal_cnt;
    logic signed [15:0] offset, comp_sat;
    logic signed [16:0] comp;
    logic               cal_last;

    always_comb begin
        cal_sum   = cal_acc + 27'(yaw_rt);
        cal_last  = vld && cal_cnt == CAL_LAST;
        comp      = 17'(yaw_rt) - 17'(offset);
        comp_sat  = (comp > 17'sh07FFF) ? 16'sh7FFF : (comp < -17'sh08000) ? 16'sh8000 : comp[15:0];
        delta     = moving ? 27'(comp_sat) : 27'sd0;
        delta     = (moving && en_fusion) ? delta + (27'(IR_Dtrm) <<< FUS_SHL) : delta;
        acc_sum   = acc + delta;
        state_nxt = strt_cal ? CAL : (state == CAL && cal_last) ? RUN : state;
    end

    // strt_cal wins over any vld in the same cycle, so that sample is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cal_acc  <= '0;
            cal_cnt  <= '0;
            offset   <= '0;
            acc      <= '0;
            heading  <= '0;
            rdy      <= 1'b0;
            cal_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            rdy      <= 1'b0;
            cal_done <= 1'b0;
            if (strt_cal) begin
                cal_acc <= '0;
                cal_cnt <= '0;
                acc     <= '0;
                heading <= '0;
            end else if (state == CAL && vld) begin
                cal_acc <= cal_sum;
                cal_cnt <= cal_cnt + 12'd1;
                if (cal_last) begin
                    offset   <= 16'(cal_sum >>> CAL_LOG2);
                    cal_done <= 1'b1;
                end
            end else if (state == RUN && vld) begin
                acc     <= acc_sum;
                heading <= acc_sum[26:15];
                rdy     <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_yaw_integrator.sv
// tb_yaw_integrator: directed checks of calibration, integration, saturation, fusion, wrap and restart behaviour.
module tb_yaw_integrator;
    logic        clk = 1'b0, rst_n = 1'b0, strt_cal = 1'b0, vld = 1'b0, moving = 1'b0, en_fusion = 1'b0;
    logic [15:0] yaw_rt = '0;
    logic [8:0]  IR_Dtrm = '0;
    logic        cal_done, rdy;
    logic [11:0] heading;
    int          n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    yaw_integrator #(.FAST_SIM(1'b1), .FUS_SHL(6)) dut (
        .clk(clk), .rst_n(rst_n), .strt_cal(strt_cal), .vld(vld), .yaw_rt(yaw_rt),
        .moving(moving), .en_fusion(en_fusion), .IR_Dtrm(IR_Dtrm),
        .cal_done(cal_done), .rdy(rdy), .heading(heading)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] y, input logic m, input logic f, input logic [8:0] ir);
        vld = 1'b1; yaw_rt = y; moving = m; en_fusion = f; IR_Dtrm = ir;
        tick();
        vld = 1'b0;
    endtask

    // restart calibration, feed 256 samples, verify single cal_done pulse after the last one
    task automatic calib(input logic [15:0] y, input bit with_vld);
        int cd, rd;
        cd = 0; rd = 0;
        strt_cal = 1'b1; vld = with_vld; yaw_rt = 16'h7FFF; moving = 1'b1;
        tick();
        strt_cal = 1'b0; vld = 1'b0;
        check("start_rdy", rdy, 0);
        check("start_heading", heading, 0);
        for (int i = 0; i < 256; i++) begin
            send(y, 1'b0, 1'b0, 9'h0);
            if (i < 255) cd += cal_done;
            rd += rdy;
        end
        check("cal_done_early", cd, 0);
        check("cal_rdy", rd, 0);
        check("cal_done_pulse", cal_done, 1);
        tick();
        check("cal_done_width", cal_done, 0);
    endtask

    initial begin
        int acc_o, cnt;
        // 1: reset with toggling inputs, IDLE ignores vld
        acc_o = 0;
        for (int i = 0; i < 6; i++) begin
            strt_cal = i[0]; vld = 1'b1; moving = i[1]; en_fusion = 1'b1; yaw_rt = 16'h1234 + 16'(i);
            tick();
            acc_o += int'(rdy) + int'(cal_done) + int'(heading);
        end
        check("reset_outputs", acc_o, 0);
        strt_cal = 1'b0; vld = 1'b0;
        rst_n = 1'b1;
        tick();
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            send(16'h4000, 1'b1, 1'b0, 9'h0);
            cnt += int'(rdy) + int'(cal_done);
        end
        check("idle_no_rdy", cnt, 0);
        check("idle_heading", heading, 0);

        // 2: offset 0x40, matching samples leave heading at 0
        calib(16'h0040, 1'b0);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            send(16'h0040, 1'b1, 1'b0, 9'h0);
            cnt += rdy;
        end
        check("run_rdy_count", cnt, 5);
        check("run_zero_heading", heading, 12'h000);
        tick();
        check("rdy_width", rdy, 0);

        // 3: two max samples -> acc 0xFFFE -> heading 1; not moving holds it
        calib(16'h0000, 1'b0);
        send(16'h7FFF, 1'b1, 1'b0, 9'h0);
        check("max_one", heading, 12'h000);
        send(16'h7FFF, 1'b1, 1'b0, 9'h0);
        check("max_two", heading, 12'h001);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            send(16'h7FFF, 1'b0, 1'b1, 9'h0FF);
            cnt += rdy;
        end
        check("still_rdy_count", cnt, 10);
        check("still_heading", heading, 12'h001);

        // 4: offset -256, comp saturates at 0x7FFF (0x80FF would give 1 then 2)
        calib(16'hFF00, 1'b0);
        send(16'h7FFF, 1'b1, 1'b0, 9'h0);
        check("sat_one", heading, 12'h000);
        send(16'h7FFF, 1'b1, 1'b0, 9'h0);
        check("sat_two", heading, 12'h001);

        // 5: fusion -256<<6 twice -> acc -32768 -> 0xFFF, then wrap back to 0
        calib(16'h0000, 1'b0);
        send(16'h0000, 1'b1, 1'b1, 9'h100);
        check("fus_one", heading, 12'hFFF);
        send(16'h0000, 1'b1, 1'b1, 9'h100);
        check("fus_two", heading, 12'hFFF);
        send(16'h0000, 1'b1, 1'b0, 9'h100);
        check("fus_disabled", heading, 12'hFFF);
        send(16'h7FFF, 1'b1, 1'b0, 9'h0);
        send(16'h7FFF, 1'b1, 1'b0, 9'h0);
        check("wrap_to_zero", heading, 12'h000);
        calib(16'h0000, 1'b0);
        send(16'h0000, 1'b0, 1'b1, 9'h100);
        send(16'h0000, 1'b0, 1'b1, 9'h100);
        check("fus_not_moving", heading, 12'h000);

        // 6: strt_cal with vld in RUN drops that sample; reset mid-CAL returns to IDLE
        send(16'h7FFF, 1'b1, 1'b0, 9'h0);
        send(16'h7FFF, 1'b1, 1'b0, 9'h0);
        check("pre_restart", heading, 12'h001);
        calib(16'h0000, 1'b1);
        strt_cal = 1'b1;
        tick();
        strt_cal = 1'b0;
        for (int i = 0; i < 100; i++) send(16'h0010, 1'b1, 1'b0, 9'h0);
        rst_n = 1'b0;
        #1;
        check("async_reset", int'(rdy) + int'(cal_done) + int'(heading), 0);
        tick();
        rst_n = 1'b1;
        tick();
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            send(16'h0010, 1'b1, 1'b0, 9'h0);
            cnt += int'(rdy) + int'(cal_done);
        end
        check("no_cal_after_reset", cnt, 0);
        check("heading_after_reset", heading, 12'h000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
